// File: rtl/return_stack_pkg.sv
// Shared definitions for the call/return address stack: default sizing and
// the per-cycle operation decode used by the stack datapath.
package return_stack_pkg;

  localparam int RS_ADDR_W = 19;
  localparam int RS_DEPTH  = 8;

  typedef enum logic [2:0] {
    RS_HOLD,
    RS_PUSH,
    RS_POP,
    RS_REPLACE,
    RS_OVERFLOW,
    RS_UNDERFLOW
  } rs_op_e;

  // Simultaneous push/pop on a non-empty stack overwrites the top in place;
  // on an empty stack it degrades to a plain push with no underflow.
  function automatic rs_op_e rs_decode(input logic push, input logic pop,
                                       input logic is_empty, input logic is_full);
    if (push && pop) return is_empty ? RS_PUSH : RS_REPLACE;
    if (push)        return is_full ? RS_OVERFLOW : RS_PUSH;
    if (pop)         return is_empty ? RS_UNDERFLOW : RS_POP;
    return RS_HOLD;
  endfunction

endpackage

// File: rtl/return_stack.sv
// Call/return address stack beside the ID stage. ret_addr is combinational
// from state so a RET can redirect the PC in the same cycle it is decoded.
module return_stack
  import return_stack_pkg::*;
#(
  parameter int ADDR_W = RS_ADDR_W,
  parameter int DEPTH  = RS_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [ADDR_W-1:0]         push_addr,
  input  logic                      clr_err,
  output logic [ADDR_W-1:0]         ret_addr,
  output logic                      empty,
  output logic                      full,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      err_overflow,
  output logic                      err_underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0]  sp_reg, sp_next;
  logic [PTR_W-1:0]  top_idx;
  logic [PTR_W-1:0]  wr_idx;
  logic              wr_en;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              ovf_reg, ovf_next;
  logic              udf_reg, udf_next;
  rs_op_e            op;

  assign empty         = (count_reg == '0);
  assign full          = (count_reg == DEPTH_C);
  assign count         = count_reg;
  assign err_overflow  = ovf_reg;
  assign err_underflow = udf_reg;
  // sp points at the next free slot, so the top lives one below (wrapping).
  assign top_idx       = sp_reg - PTR_W'(1);
  assign ret_addr      = empty ? '0 : mem_reg[top_idx];

  always_comb begin
    op         = rs_decode(push, pop, empty, full);
    sp_next    = sp_reg;
    count_next = count_reg;
    wr_en      = 1'b0;
    wr_idx     = sp_reg;
    case (op)
      RS_PUSH: begin
        wr_en      = 1'b1;
        wr_idx     = sp_reg;
        sp_next    = sp_reg + PTR_W'(1);
        count_next = count_reg + CNT_W'(1);
      end
      RS_POP: begin
        sp_next    = top_idx;
        count_next = count_reg - CNT_W'(1);
      end
      RS_REPLACE: begin
        wr_en  = 1'b1;
        wr_idx = top_idx;
      end
      default: ;
    endcase
    // A new error event in the same cycle as clr_err keeps the flag set.
    ovf_next = (ovf_reg & ~clr_err) | (op == RS_OVERFLOW);
    udf_next = (udf_reg & ~clr_err) | (op == RS_UNDERFLOW);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_reg    <= '0;
      count_reg <= '0;
      ovf_reg   <= 1'b0;
      udf_reg   <= 1'b0;
    end else begin
      sp_reg    <= sp_next;
      count_reg <= count_next;
      ovf_reg   <= ovf_next;
      udf_reg   <= udf_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else if (wr_en) begin
      mem_reg[wr_idx] <= push_addr;
    end
  end

endmodule

// File: tb/tb_return_stack.sv
// Directed bench for return_stack at DEPTH=4: a vector table applied one
// operation per cycle, post-edge state checked through a scoreboard queue.
module tb_return_stack;

  localparam int ADDR_W = 19;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              push = 1'b0;
  logic              pop = 1'b0;
  logic [ADDR_W-1:0] push_addr = '0;
  logic              clr_err = 1'b0;
  logic [ADDR_W-1:0] ret_addr;
  logic              empty, full;
  logic [2:0]        count;
  logic              err_overflow, err_underflow;

  int total = 0;
  int bad   = 0;

  return_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .push_addr(push_addr),
    .clr_err(clr_err), .ret_addr(ret_addr), .empty(empty), .full(full),
    .count(count), .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              push, pop, clr;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] ret_now;
    logic [ADDR_W-1:0] ret_post;
    int                cnt;
    logic              emp, ful, ovf, udf;
  } vec_t;

  typedef struct {
    logic [ADDR_W-1:0] ret;
    int                cnt;
    logic              emp, ful, ovf, udf;
  } exp_t;

  vec_t vecs[25];
  exp_t sb_q[$];

  function automatic vec_t mk(logic pu, logic po, logic cl, logic [ADDR_W-1:0] a,
                              logic [ADDR_W-1:0] rn, logic [ADDR_W-1:0] rp,
                              int c, logic e, logic f, logic o, logic u);
    vec_t v;
    v.push = pu; v.pop = po; v.clr = cl; v.addr = a;
    v.ret_now = rn; v.ret_post = rp; v.cnt = c;
    v.emp = e; v.ful = f; v.ovf = o; v.udf = u;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_idle_state(string tag);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_ret"}, 32'(ret_addr), 32'd0);
    chk({tag, "_ovf"}, 32'(err_overflow), 32'd0);
    chk({tag, "_udf"}, 32'(err_underflow), 32'd0);
  endtask

  // One operation: drive on the falling edge, check the combinational
  // ret_addr in that cycle, then compare registered state after the edge.
  task automatic step(input vec_t v, input int idx);
    exp_t e;
    exp_t got;
    @(negedge clk);
    push = v.push; pop = v.pop; clr_err = v.clr; push_addr = v.addr;
    #1;
    chk($sformatf("v%0d_ret_now", idx), 32'(ret_addr), 32'(v.ret_now));
    e.ret = v.ret_post; e.cnt = v.cnt; e.emp = v.emp; e.ful = v.ful;
    e.ovf = v.ovf; e.udf = v.udf;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    got = sb_q.pop_front();
    chk($sformatf("v%0d_ret_post", idx), 32'(ret_addr), 32'(got.ret));
    chk($sformatf("v%0d_count", idx), 32'(count), 32'(got.cnt));
    chk($sformatf("v%0d_empty", idx), 32'(empty), 32'(got.emp));
    chk($sformatf("v%0d_full", idx), 32'(full), 32'(got.ful));
    chk($sformatf("v%0d_ovf", idx), 32'(err_overflow), 32'(got.ovf));
    chk($sformatf("v%0d_udf", idx), 32'(err_underflow), 32'(got.udf));
    $display("op %0d: push=%0d pop=%0d clr=%0d addr=0x%05h ret=0x%05h count=%0d ovf=%0d udf=%0d",
             idx, v.push, v.pop, v.clr, v.addr, ret_addr, count, err_overflow, err_underflow);
  endtask

  initial begin
    //           push pop clr addr       ret_now    ret_post  cnt e f o u
    vecs[0]  = mk(1, 0, 0, 19'h00100, 19'h00000, 19'h00100, 1, 0, 0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 19'h00200, 19'h00100, 19'h00200, 2, 0, 0, 0, 0);
    vecs[2]  = mk(1, 0, 0, 19'h00300, 19'h00200, 19'h00300, 3, 0, 0, 0, 0);
    vecs[3]  = mk(0, 1, 0, 19'h00000, 19'h00300, 19'h00200, 2, 0, 0, 0, 0);
    vecs[4]  = mk(0, 1, 0, 19'h00000, 19'h00200, 19'h00100, 1, 0, 0, 0, 0);
    vecs[5]  = mk(0, 1, 0, 19'h00000, 19'h00100, 19'h00000, 0, 1, 0, 0, 0);
    vecs[6]  = mk(1, 0, 0, 19'h00A00, 19'h00000, 19'h00A00, 1, 0, 0, 0, 0);
    vecs[7]  = mk(0, 1, 0, 19'h00000, 19'h00A00, 19'h00000, 0, 1, 0, 0, 0);
    vecs[8]  = mk(0, 1, 0, 19'h00000, 19'h00000, 19'h00000, 0, 1, 0, 0, 1);
    vecs[9]  = mk(0, 0, 1, 19'h00000, 19'h00000, 19'h00000, 0, 1, 0, 0, 0);
    vecs[10] = mk(0, 1, 0, 19'h00000, 19'h00000, 19'h00000, 0, 1, 0, 0, 1);
    vecs[11] = mk(0, 1, 1, 19'h00000, 19'h00000, 19'h00000, 0, 1, 0, 0, 1);
    vecs[12] = mk(0, 0, 1, 19'h00000, 19'h00000, 19'h00000, 0, 1, 0, 0, 0);
    vecs[13] = mk(1, 0, 0, 19'h00011, 19'h00000, 19'h00011, 1, 0, 0, 0, 0);
    vecs[14] = mk(1, 0, 0, 19'h00022, 19'h00011, 19'h00022, 2, 0, 0, 0, 0);
    vecs[15] = mk(1, 0, 0, 19'h00033, 19'h00022, 19'h00033, 3, 0, 0, 0, 0);
    vecs[16] = mk(1, 0, 0, 19'h00044, 19'h00033, 19'h00044, 4, 0, 1, 0, 0);
    vecs[17] = mk(1, 0, 0, 19'h7FFFF, 19'h00044, 19'h00044, 4, 0, 1, 1, 0);
    vecs[18] = mk(0, 0, 1, 19'h00000, 19'h00044, 19'h00044, 4, 0, 1, 0, 0);
    vecs[19] = mk(0, 1, 0, 19'h00000, 19'h00044, 19'h00033, 3, 0, 0, 0, 0);
    vecs[20] = mk(0, 1, 0, 19'h00000, 19'h00033, 19'h00022, 2, 0, 0, 0, 0);
    vecs[21] = mk(1, 1, 0, 19'h12345, 19'h00022, 19'h12345, 2, 0, 0, 0, 0);
    vecs[22] = mk(0, 1, 0, 19'h00000, 19'h12345, 19'h00011, 1, 0, 0, 0, 0);
    vecs[23] = mk(0, 1, 0, 19'h00000, 19'h00011, 19'h00000, 0, 1, 0, 0, 0);
    vecs[24] = mk(1, 1, 0, 19'h00555, 19'h00000, 19'h00555, 1, 0, 0, 0, 0);

    #2;
    check_idle_state("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 25; i++) step(vecs[i], i);

    // Drain, refill to three, then assert reset between clock edges.
    step(mk(0, 1, 0, 19'h00000, 19'h00555, 19'h00000, 0, 1, 0, 0, 0), 25);
    step(mk(1, 0, 0, 19'h00101, 19'h00000, 19'h00101, 1, 0, 0, 0, 0), 26);
    step(mk(1, 0, 0, 19'h00202, 19'h00101, 19'h00202, 2, 0, 0, 0, 0), 27);
    step(mk(1, 0, 0, 19'h00303, 19'h00202, 19'h00303, 3, 0, 0, 0, 0), 28);
    step(mk(1, 1, 1, 19'h00404, 19'h00303, 19'h00404, 3, 0, 0, 0, 0), 29);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_idle_state("async_rst");
    @(negedge clk);
    rst = 1'b0;
    step(mk(1, 0, 0, 19'h00777, 19'h00000, 19'h00777, 1, 0, 0, 0, 0), 30);
    step(mk(0, 1, 0, 19'h00000, 19'h00777, 19'h00000, 0, 1, 0, 0, 0), 31);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
